// File: rtl/reg_bank4_pkg.sv
// Purpose: shared constants, types and write-select classifier for the 4-entry register bank.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package regfile_pkg;

  localparam int NREG      = 4;
  localparam int ADDR_W    = 2;
  localparam int CNT_W     = 8;
  localparam int DEF_WIDTH = 64;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Classification of a write-select vector by how many bits are set.
  typedef enum logic [1:0] {
    SEL_NONE  = 2'd0,
    SEL_ONE   = 2'd1,
    SEL_MULTI = 2'd2
  } sel_kind_e;

  // Popcount-based classification: exactly one bit is a legal write,
  // two or more is a select error, zero is idle.
  function automatic sel_kind_e classify_sel(input logic [NREG-1:0] sel);
    logic [2:0] cnt;
    cnt = '0;
    for (int i = 0; i < NREG; i++) begin
      cnt = cnt + 3'(sel[i]);
    end
    if (cnt == 3'd0) begin
      return SEL_NONE;
    end else if (cnt == 3'd1) begin
      return SEL_ONE;
    end else begin
      return SEL_MULTI;
    end
  endfunction

endpackage

// File: rtl/reg_bank4_if.sv
// Purpose: write/read bus of the 4-entry register bank (master = client, slave = bank).
// Latency: reads combinational, writes land on the next rising clk.
// Backpressure: none; every legal write is accepted.
interface reg_bank4_if #(
  parameter int WIDTH = regfile_pkg::DEF_WIDTH
);
  import regfile_pkg::*;

  logic [NREG-1:0]   wr_onehot;
  logic [WIDTH-1:0]  wr_data;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [WIDTH-1:0]  rd_data_a;
  logic [WIDTH-1:0]  rd_data_b;
  logic              sel_err;
  logic [CNT_W-1:0]  wr_count;

  modport master (
    output wr_onehot, wr_data, rd_addr_a, rd_addr_b,
    input  rd_data_a, rd_data_b, sel_err, wr_count
  );

  modport slave (
    input  wr_onehot, wr_data, rd_addr_a, rd_addr_b,
    output rd_data_a, rd_data_b, sel_err, wr_count
  );

endinterface

// File: rtl/reg_bank4_reg_n.sv
// Purpose: one WIDTH-bit storage register with synchronous reset and load enable.
// Latency: loaded value visible one cycle after the enabled edge.
// Backpressure: none.
module reg_n #(
  parameter int WIDTH = regfile_pkg::DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  // Reset has priority over a load on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/reg_bank4.sv
// Purpose: 4-entry register bank, one one-hot write port, two combinational read ports.
// Latency: writes visible after the edge (no bypass), reads zero-cycle.
// Backpressure: none; multi-hot selects are dropped and flagged in a sticky error.
module reg_bank4 #(
  parameter int WIDTH     = regfile_pkg::DEF_WIDTH,
  parameter bit ZERO_LAST = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  reg_bank4_if.slave bus
);
  import regfile_pkg::*;

  sel_kind_e        w_sel_kind;
  logic             w_wr_one;
  logic             w_wr_multi;
  logic [WIDTH-1:0] w_reg_q [NREG];
  logic             r_sel_err;
  logic [CNT_W-1:0] r_wr_count;

  // Single shared legality term used by the storage enables, counter and error flag.
  assign w_sel_kind = classify_sel(bus.wr_onehot);
  assign w_wr_one   = (w_sel_kind == SEL_ONE);
  assign w_wr_multi = (w_sel_kind == SEL_MULTI);

  for (genvar g = 0; g < NREG; g++) begin : g_reg
    if (ZERO_LAST && (g == NREG - 1)) begin : g_zero
      // Last entry is a hardwired zero; writes to it are accepted but dropped.
      assign w_reg_q[g] = '0;
    end else begin : g_store
      reg_n #(.WIDTH(WIDTH)) u_reg (
        .clk   (clk),
        .reset (reset),
        .i_en  (w_wr_one & bus.wr_onehot[g]),
        .i_d   (bus.wr_data),
        .o_q   (w_reg_q[g])
      );
    end
  end

  // Sticky select error: set by any multi-hot select, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sel_err <= 1'b0;
    end else if (w_wr_multi) begin
      r_sel_err <= 1'b1;
    end
  end

  // Accepted-write counter, saturating so it never wraps back to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_count <= '0;
    end else if (w_wr_one && (r_wr_count != CNT_MAX)) begin
      r_wr_count <= r_wr_count + 1'b1;
    end
  end

  // Read port A: 4:1 mux over current register state.
  always_comb begin
    bus.rd_data_a = '0;
    case (bus.rd_addr_a)
      2'd0: bus.rd_data_a = w_reg_q[0];
      2'd1: bus.rd_data_a = w_reg_q[1];
      2'd2: bus.rd_data_a = w_reg_q[2];
      2'd3: bus.rd_data_a = w_reg_q[3];
      default: bus.rd_data_a = '0;
    endcase
  end

  // Read port B: independent 4:1 mux over the same register state.
  always_comb begin
    bus.rd_data_b = '0;
    case (bus.rd_addr_b)
      2'd0: bus.rd_data_b = w_reg_q[0];
      2'd1: bus.rd_data_b = w_reg_q[1];
      2'd2: bus.rd_data_b = w_reg_q[2];
      2'd3: bus.rd_data_b = w_reg_q[3];
      default: bus.rd_data_b = '0;
    endcase
  end

  assign bus.sel_err  = r_sel_err;
  assign bus.wr_count = r_wr_count;

endmodule

// File: doc/reg_bank4.md
REG_BANK4 -- requirements
Module: reg_bank4

Interface
REQ-001 Parameter: WIDTH, 64, data width of each register and each port.
REQ-002 Parameter: ZERO_LAST, 1, when 1 register 3 is hardwired to zero.
REQ-003 Port: clk  input  1  sole clock, all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 Port: wr_onehot  input  4  one-hot write select, bit i selects register i; driven by the upstream 2-to-4 decoder output.
REQ-006 Port: wr_data  input  WIDTH  data written to the selected register.
REQ-007 Port: rd_addr_a  input  2  read port A register index.
REQ-008 Port: rd_addr_b  input  2  read port B register index.
REQ-009 Port: rd_data_a  output  WIDTH  contents of register rd_addr_a.
REQ-010 Port: rd_data_b  output  WIDTH  contents of register rd_addr_b.
REQ-011 Port: sel_err  output  1  sticky flag, set when more than one wr_onehot bit is sampled high.
REQ-012 Port: wr_count  output  8  number of accepted writes since reset, saturating.

Function
REQ-013 Write: on a rising clk with popcount(wr_onehot)==1, the selected register SHALL load wr_data; all other registers SHALL hold.
REQ-014 wr_onehot==0: no register changes, wr_count holds.
REQ-015 popcount(wr_onehot)>=2: no register changes, sel_err SHALL be 1 from the next cycle, and wr_count holds.
REQ-016 sel_err SHALL stay 1 until reset; only reset clears it.
REQ-017 Reads are combinational, with zero-cycle latency from rd_addr_* and register state.
REQ-018 Same-cycle read of the register being written returns the old value; the new value is visible after the edge. There is no bypass.
REQ-019 Both read ports may address the same register and SHALL return identical data.
REQ-020 ZERO_LAST=1: rd_data_* for index 3 SHALL be 0; a write to register 3 is discarded but still counts as accepted in wr_count.
REQ-021 ZERO_LAST=0: register 3 behaves like registers 0-2.
REQ-022 wr_count increments by 1 per accepted write and SHALL saturate at 255, never wrapping to 0.
REQ-023 When reset and a write are sampled on the same edge, reset SHALL win: no write occurs and there is no count increment.

Reset
REQ-024 On reset, all registers, wr_count and sel_err SHALL be 0.
REQ-025 rd_data_* SHALL therefore read 0 on the cycle after reset.
REQ-026 Reset mid-sequence discards the in-flight write and any sticky error.

Structure
REQ-027 Shared package regfile_pkg SHALL hold:
- NREG=4
- ADDR_W=2
- CNT_W=8
- default WIDTH=64
REQ-028 The per-register storage SHALL be a sub-module reg_n:
- WIDTH-bit register with synchronous reset and enable
- instantiated once per register
REQ-029 Read selection SHALL be a 4:1 mux per port, with no latches inferred.
REQ-030 The one-hot check (popcount==1, popcount>=2) SHALL be a single shared combinational term.

Verification
REQ-031 Reset, then read all four indices on both ports -> all 0, sel_err=0, wr_count=0.
REQ-032 Write 0xA5 to reg0 (wr_onehot=0001), then 0x5A to reg2 (0100) -> rd_addr_a=0 gives 0xA5, rd_addr_b=2 gives 0x5A, wr_count=2.
REQ-033 ZERO_LAST=1, write 0xFFFF to reg3 (1000) -> rd_data for index 3 is 0, wr_count increments by 1.
REQ-034 wr_onehot=0011 with wr_data=0x77 -> reg0 and reg1 unchanged, sel_err=1 next cycle and still 1 after ten idle cycles.
REQ-035 Write 0x11 to reg1 while reading reg1 in the same cycle -> old value during the cycle, 0x11 after the edge.
REQ-036 300 consecutive legal writes -> wr_count=255, then reset with a concurrent write -> all outputs 0, target register 0.
